pc_fetch: RTL
=============

// Module: pc_fetch
// PURPOSE
//  Instruction-fetch stage: owns the program counter, issues word fetches to the
//  instruction memory over a req/ack handshake, and presents one instruction per
//  cycle (or a NOP bubble) to the IF/ID pipeline register's InstIn.
//  Handles pipeline pause, control-flow redirects, and variable-latency memory,
//  including squashing of in-flight wrong-path fetches.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset (word aligned)
//  NOP_INST   32'h0000_0000  bubble encoding driven when no valid instruction
// PORTS
//  clk             in   1   clock, all state updates on posedge
//  rst             in   1   reset: synchronous, active-low
//  pause           in   1   hazard stall; same signal that holds IF/ID
//  redirect_valid  in   1   branch/jump taken this cycle
//  redirect_pc     in   32  target PC; bits [1:0] ignored (forced 0)
//  imem_req        out  1   fetch request, held until imem_ack
//  imem_addr       out  32  fetch address, stable while imem_req && !imem_ack
//  imem_ack        in   1   rdata valid this cycle; meaningful only when imem_req=1
//  imem_rdata      in   32  fetched word
//  inst_out        out  32  instruction to IF/ID InstIn (combinational)
//  inst_pc         out  32  PC of inst_out (combinational)
//  inst_valid      out  1   inst_out is a real instruction, not a bubble
//  fetch_busy      out  1   fetch outstanding without ack this cycle
// BEHAVIOUR
//  State: pc_q[31:0], hold_q[31:0], state in {FETCH, HOLD, DRAIN}.
//  Reset (rst=0 at edge): pc_q<=RESET_PC, hold_q<=0, state<=FETCH.
//   While rst=0: imem_req=0, inst_valid=0, inst_out=NOP_INST, fetch_busy=0.
//  FETCH: imem_req=1, imem_addr=pc_q; ack may arrive same cycle (0 wait) or later.
//   - ack && !pause: inst_out=imem_rdata, inst_pc=pc_q, inst_valid=1;
//     edge: pc_q<=pc_q+4, stay FETCH.
//   - ack && pause: inst_valid=0, inst_out=NOP_INST; edge: hold_q<=imem_rdata, ->HOLD.
//   - !ack: inst_valid=0, inst_out=NOP_INST, fetch_busy=1; stay FETCH.
//  HOLD: imem_req=0. inst_out=hold_q, inst_pc=pc_q, inst_valid=!pause.
//   - !pause: edge: pc_q<=pc_q+4, ->FETCH. pause: stay HOLD.
//  DRAIN: old fetch outstanding after redirect; imem_req=1, imem_addr=old addr
//   (pc_q retains the abandoned address, new target in a separate redir_q).
//   inst_valid=0, inst_out=NOP_INST, fetch_busy=!ack.
//   - ack: data discarded; edge: pc_q<=redir_q, ->FETCH.
//  Redirect (redirect_valid=1) priority: rst > redirect > pause > normal.
//   - Redirect cycle: inst_valid=0, inst_out=NOP_INST (no delay slot; any ack data,
//     including same-cycle ack, is discarded).
//   - From FETCH with ack, or from HOLD: edge: pc_q<=redirect_pc&~3, ->FETCH, hold_q dropped.
//   - From FETCH without ack: edge: redir_q<=redirect_pc&~3, ->DRAIN.
//   - In DRAIN: newer redirect overwrites redir_q; if ack same cycle go FETCH with newest target.
//   - Redirect while pause=1 still taken.
//  Arithmetic: pc_q+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
//  imem_addr and imem_req never change while a request is un-acked (handshake rule).
//  Reset mid-fetch: request abandoned; memory must tolerate imem_req dropping.
//  Throughput: 1 instruction/cycle with 0-wait memory and no pause/redirect.
// TESTING
//  1 Reset, 0-wait memory returning addr as data, pause=0 for 4 cycles -> inst_pc
//    0,4,8,C with inst_valid=1 each cycle; imem_req=0 while rst=0.
//  2 Memory with 2-cycle ack latency -> each fetch yields 2 bubble cycles with
//    fetch_busy=1, imem_addr stable, then inst_valid=1 on ack; PC 0->4.
//  3 ack at PC=0x8 with pause=1 for 3 cycles -> HOLD, inst_valid=0, then on pause
//    release inst_out=word@0x8, inst_valid=1, next fetch address 0xC.
//  4 redirect_valid with redirect_pc=0x103 while fetch to 0x10 un-acked (latency 3)
//    -> DRAIN keeps imem_addr=0x10 until ack, data discarded, next imem_addr=0x100.
//  5 Same-cycle ack and redirect to 0x40 -> inst_valid=0 that cycle, next addr 0x40;
//    redirect during pause in HOLD -> held word dropped, fetch 0x40.
//  6 RESET_PC=0xFFFF_FFFC -> first fetch 0xFFFF_FFFC, next 0x0000_0000; rst=0
//    asserted mid-DRAIN -> imem_req=0, PC returns to RESET_PC.

Source files
------------

// File: rtl/pc_fetch.sv
// Instruction-fetch stage. Owns the program counter and fetches one word at a
// time over a req/ack handshake. It presents one instruction per cycle, or a NOP
// bubble, to the IF/ID register. It handles pause, redirects and wrong-path
// fetches that are still in flight.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_busy
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg,    pc_next;
  logic [31:0] hold_reg,  hold_next;
  logic [31:0] redir_reg, redir_next;
  logic [31:0] redir_target;
  logic [31:0] pc_plus4;

  // Redirect targets are always word aligned. The PC increment wraps modulo 2^32.
  assign redir_target = redirect_pc & ~32'h0000_0003;
  assign pc_plus4     = pc_reg + 32'd4;

  // The address always follows pc_reg. In DRAIN, pc_reg still holds the
  // abandoned address, so the address stays stable until the old fetch is acked.
  assign imem_addr = pc_reg;
  assign inst_pc   = pc_reg;

  // Outputs to memory and to IF/ID. A redirect cycle always produces a bubble.
  always_comb begin
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    inst_out   = NOP_INST;
    fetch_busy = 1'b0;
    if (rst) begin
      case (state_reg)
        FETCH: begin
          imem_req   = 1'b1;
          fetch_busy = !imem_ack;
          if (imem_ack && !pause && !redirect_valid) begin
            inst_valid = 1'b1;
            inst_out   = imem_rdata;
          end
        end
        HOLD: begin
          if (!redirect_valid) begin
            inst_out   = hold_reg;
            inst_valid = !pause;
          end
        end
        DRAIN: begin
          imem_req   = 1'b1;
          fetch_busy = !imem_ack;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  // Next-state selection. Priority is redirect, then pause, then normal flow.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    hold_next  = hold_reg;
    redir_next = redir_reg;
    case (state_reg)
      FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_next = redir_target;
          end else begin
            redir_next = redir_target;
            state_next = DRAIN;
          end
        end else if (imem_ack) begin
          if (pause) begin
            hold_next  = imem_rdata;
            state_next = HOLD;
          end else begin
            pc_next = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next    = redir_target;
          hold_next  = 32'd0;
          state_next = FETCH;
        end else if (!pause) begin
          pc_next    = pc_plus4;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        // The data returned by the abandoned fetch is never used.
        if (imem_ack) begin
          pc_next    = redirect_valid ? redir_target : redir_reg;
          state_next = FETCH;
        end else if (redirect_valid) begin
          redir_next = redir_target;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      hold_reg  <= 32'd0;
      redir_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      hold_reg  <= hold_next;
      redir_reg <= redir_next;
    end
  end

endmodule
